iq_scheduler: RTL
=================

# iq_scheduler

Issue scheduler and slot allocator paired with the instruction queue storage array. It owns per-entry occupancy and operand-readiness state and allocates a free slot for each dispatched instruction, driving the queue write address. It wakes sources on result-tag broadcasts and selects one ready entry per cycle, driving the queue read port toward execute.

## Interface
Parameters:
- ENTRIES, 64, queue depth
- ADDR_WIDTH, $clog2(ENTRIES), slot index width
- PHYS_COUNT, 128, physical register count
- PHYS_ADDR_WIDTH, $clog2(PHYS_COUNT), physical tag width
- WAKEUP_PORTS, 2, result-tag broadcast ports

Ports (clock is `clk`; reset is `async_rst_n`, asynchronous, active-low):
- clk  in  1  clock
- async_rst_n  in  1  asynchronous active-low reset
- clk_en  in  1  global clock enable; low freezes all state
- flush  in  1  synchronous clear of all entries
- disp_valid  in  1  dispatch request
- disp_ready  out  1  slot available
- disp_src_addr[2]  in  PHYS_ADDR_WIDTH  source tags
- disp_src_ready[2]  in  1  source already available at dispatch
- queue_wr_en  out  1  queue write strobe
- queue_wr_addr  out  ADDR_WIDTH  allocated slot
- wake_valid[WAKEUP_PORTS]  in  1  broadcast valid
- wake_tag[WAKEUP_PORTS]  in  PHYS_ADDR_WIDTH  completing destination tag
- issue_ready  in  1  execute accepts an instruction
- queue_rd_en  out  1  queue read strobe (issue)
- queue_rd_addr  out  ADDR_WIDTH  selected slot
- occupancy  out  ADDR_WIDTH+1  valid entry count

## Operation
- Per entry: valid, src_tag[2], src_rdy[2]. Reset/flush clear valid and src_rdy.
- Allocation: lowest-index entry with valid=0, from registered state. disp_ready = any free & clk_en & !flush. queue_wr_en = disp_valid & disp_ready; queue_wr_addr = allocated index (undefined-but-stable 0 when none free).
- On write edge: valid=1, tags stored, src_rdy[i] = disp_src_ready[i] OR (any wake_valid[k] with wake_tag[k]==disp_src_addr[i]) — same-cycle wakeup bypass.
- Wakeup: every valid entry sets src_rdy[i] when any valid wake port matches src_tag[i]. Multiple matching ports are idempotent.
- Eligible = valid & src_rdy[0] & src_rdy[1]. Select per selection policy (Configuration). queue_rd_en = any eligible & issue_ready & clk_en & !flush; queue_rd_addr = selected index. The selected entry clears valid at that edge.
- occupancy: +1 on write, −1 on issue, net 0 when both; 0 on flush.

## Timing
- Reset: all state cleared; while async_rst_n low, disp_ready=0, queue_wr_en=0, queue_rd_en=0, queue_wr_addr=0, queue_rd_addr=0, occupancy=0. First cycle after release: disp_ready=1.
- Dispatch→earliest issue: 1 cycle (entry eligible the cycle after its write edge if both sources ready).
- Wakeup in cycle W → eligible in W+1.
- Slot freed by issue at edge N is allocatable from cycle N+1 (no same-cycle reuse). Full queue gives disp_ready=0 even if issuing that cycle.
- flush: wins over dispatch and issue that cycle; both strobes 0; all entries invalid next cycle.
- clk_en low: state holds, strobes and disp_ready 0; wakeups that cycle are dropped.

## Configuration
- IQ_AGE_SELECT_EN defined: ENTRIES×ENTRIES age matrix; select issues the oldest eligible entry; matrix row/column updated on allocate, ignored on free.
- Undefined: select issues the lowest-index eligible entry; no age state.

## Structure
- Package iq_pkg: iq_entry_t struct (valid, src_tag[2], src_rdy[2]), operand count constant (2).
- Sub-module iq_prio_enc (lowest-set-bit encoder, one-hot-found flag), instantiated for allocation and for lowest-index select.

## Test plan
- Reset, dispatch tag srcs {5,9} ready {1,1} → queue_wr_addr=0 that cycle; queue_rd_en=1, rd_addr=0 next cycle with issue_ready=1.
- Dispatch srcs {5,9} ready {0,0}; wake tag 5 at cycle 3, tag 9 at cycle 6 → issue at cycle 7, not before.
- Dispatch with src 12 unready while wake_tag=12 same cycle → entry issues next cycle (bypass).
- Fill 64 entries unready → disp_ready=0, occupancy=64; wake all, issue one → disp_ready=1 the following cycle, wr_addr=freed slot.
- Entries 3 then 1 allocated (1 younger), both ready: with IQ_AGE_SELECT_EN rd_addr=3; without, rd_addr=1.
- Flush with dispatch and issue pending → no strobes, occupancy=0 next cycle; async_rst_n pulse mid-stream → all outputs 0 immediately.

Source files
------------

// File: rtl/iq_pkg.sv
// Shared types for the issue-queue scheduler: per-entry state and operand count.
package iq_pkg;
  localparam int NUM_SRC   = 2;
  // Tags are stored zero-extended to a fixed width so the struct is parameter-free.
  localparam int TAG_MAX_W = 16;

  typedef struct packed {
    logic                              valid;
    logic [NUM_SRC-1:0][TAG_MAX_W-1:0] src_tag;
    logic [NUM_SRC-1:0]                src_rdy;
  } iq_entry_t;
endpackage

// File: rtl/iq_prio_enc.sv
// Lowest-set-bit encoder with a found flag; shared by slot allocation and select.
module iq_prio_enc #(
  parameter int N = 64,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         found
);
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[i]) idx = W'(i);
  end

  assign found = |req;
endmodule

// File: rtl/iq_scheduler.sv
// Issue scheduler / slot allocator: occupancy, operand wakeup and one-per-cycle select.
// Optional IQ_AGE_SELECT_EN: oldest-eligible select via an age matrix (default: lowest index).
module iq_scheduler
  import iq_pkg::*;
#(
  parameter int ENTRIES         = 64,
  parameter int ADDR_WIDTH      = $clog2(ENTRIES),
  parameter int PHYS_COUNT      = 128,
  parameter int PHYS_ADDR_WIDTH = $clog2(PHYS_COUNT),
  parameter int WAKEUP_PORTS    = 2
) (
  input  logic                                         clk,
  input  logic                                         async_rst_n,
  input  logic                                         clk_en,
  input  logic                                         flush,
  input  logic                                         disp_valid,
  output logic                                         disp_ready,
  input  logic [NUM_SRC-1:0][PHYS_ADDR_WIDTH-1:0]      disp_src_addr,
  input  logic [NUM_SRC-1:0]                           disp_src_ready,
  output logic                                         queue_wr_en,
  output logic [ADDR_WIDTH-1:0]                        queue_wr_addr,
  input  logic [WAKEUP_PORTS-1:0]                      wake_valid,
  input  logic [WAKEUP_PORTS-1:0][PHYS_ADDR_WIDTH-1:0] wake_tag,
  input  logic                                         issue_ready,
  output logic                                         queue_rd_en,
  output logic [ADDR_WIDTH-1:0]                        queue_rd_addr,
  output logic [ADDR_WIDTH:0]                          occupancy
);
  logic [ENTRIES-1:0]    free_vec, elig_vec, grant_vec;
  logic [ADDR_WIDTH-1:0] alloc_idx, sel_idx;
  logic                  any_free, any_elig;
  logic                  active, wr_fire, rd_fire;
  logic [NUM_SRC-1:0]    disp_rdy_eff;
  logic [ADDR_WIDTH:0]   occ_q;

  // Reset is folded in so the strobes read 0 while reset is held.
  assign active      = clk_en & ~flush & async_rst_n;
  assign disp_ready  = any_free & active;
  assign wr_fire     = disp_valid & disp_ready;
  assign rd_fire     = any_elig & issue_ready & active;
  assign queue_wr_en = wr_fire;
  assign queue_rd_en = rd_fire;
  assign queue_wr_addr = alloc_idx;
  assign queue_rd_addr = sel_idx;
  assign occupancy   = occ_q;

  // Same-cycle wakeup bypass for operands being written this edge.
  always_comb begin
    disp_rdy_eff = disp_src_ready;
    for (int s = 0; s < NUM_SRC; s++)
      for (int k = 0; k < WAKEUP_PORTS; k++)
        if (wake_valid[k] && wake_tag[k] == disp_src_addr[s]) disp_rdy_eff[s] = 1'b1;
  end

  for (genvar e = 0; e < ENTRIES; e++) begin : g_ent
    iq_entry_t          ent;
    logic [NUM_SRC-1:0] hit;

    always_comb begin
      hit = '0;
      for (int s = 0; s < NUM_SRC; s++)
        for (int k = 0; k < WAKEUP_PORTS; k++)
          if (wake_valid[k] && ent.src_tag[s] == TAG_MAX_W'(wake_tag[k])) hit[s] = 1'b1;
    end

    assign free_vec[e] = ~ent.valid;
    assign elig_vec[e] = ent.valid & (&ent.src_rdy);

    always_ff @(posedge clk or negedge async_rst_n) begin
      if (!async_rst_n) begin
        ent <= '0;
      end else if (clk_en) begin
        if (flush) begin
          ent.valid   <= 1'b0;
          ent.src_rdy <= '0;
        end else if (wr_fire && alloc_idx == ADDR_WIDTH'(e)) begin
          ent.valid   <= 1'b1;
          ent.src_rdy <= disp_rdy_eff;
          for (int s = 0; s < NUM_SRC; s++) ent.src_tag[s] <= TAG_MAX_W'(disp_src_addr[s]);
        end else begin
          if (rd_fire && sel_idx == ADDR_WIDTH'(e)) ent.valid <= 1'b0;
          if (ent.valid) ent.src_rdy <= ent.src_rdy | hit;
        end
      end
    end
  end

`ifdef IQ_AGE_SELECT_EN
  // age[i][j] set means entry i was allocated before entry j.
  logic [ENTRIES-1:0][ENTRIES-1:0] age;

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      age <= '0;
    end else if (wr_fire) begin
      for (int j = 0; j < ENTRIES; j++) age[j][alloc_idx] <= 1'b1;
      age[alloc_idx] <= '0;
    end
  end

  always_comb begin
    grant_vec = elig_vec;
    for (int i = 0; i < ENTRIES; i++)
      for (int j = 0; j < ENTRIES; j++)
        if (elig_vec[j] && age[j][i]) grant_vec[i] = 1'b0;
  end
`else
  assign grant_vec = elig_vec;
`endif

  iq_prio_enc #(.N(ENTRIES), .W(ADDR_WIDTH)) u_alloc (
    .req(free_vec), .idx(alloc_idx), .found(any_free));

  iq_prio_enc #(.N(ENTRIES), .W(ADDR_WIDTH)) u_sel (
    .req(grant_vec), .idx(sel_idx), .found(any_elig));

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n)   occ_q <= '0;
    else if (clk_en) begin
      if (flush)        occ_q <= '0;
      else              occ_q <= occ_q + (ADDR_WIDTH+1)'(wr_fire) - (ADDR_WIDTH+1)'(rd_fire);
    end
  end
endmodule
